// File: rtl/microcpu_sequencer_if.sv
// rtl/microcpu_sequencer_if.sv - instruction-memory fetch bus between sequencer and imem
interface microcpu_sequencer_if #(
    parameter int PC_WIDTH = 12
);
    logic                imem_req;
    logic [PC_WIDTH-1:0] imem_addr;
    logic [15:0]         imem_rdata;
    logic                imem_ack;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_rdata,
        input  imem_ack
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_rdata,
        output imem_ack
    );
endinterface

// File: rtl/microcpu_sequencer.sv
// rtl/microcpu_sequencer.sv - fetch/decode/execute sequencer owning pc, instr register and rf write strobe
module microcpu_sequencer #(
    parameter int                  PC_WIDTH = 12,
    parameter logic [PC_WIDTH-1:0] RESET_PC = '0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 run,
    microcpu_sequencer_if.master imem,
    output logic [15:0]          instr,
    input  logic                 cu_reg_write_enable,
    input  logic                 cu_load_pc,
    input  logic [PC_WIDTH-1:0]  cu_load_pc_val,
    output logic                 rf_write_strobe,
    output logic [PC_WIDTH-1:0]  pc,
    output logic [1:0]           state,
    output logic [15:0]          retire_count,
    output logic                 illegal_op
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        FETCH   = 2'd1,
        DECODE  = 2'd2,
        EXECUTE = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic [PC_WIDTH-1:0] pc_q, pc_d;
    logic [15:0]         instr_q, instr_d;
    logic [15:0]         retire_q, retire_d;
    logic                illegal_q, illegal_d;
    logic                req_q, req_d;

    // Opcodes above 6 are undefined; their control-unit requests are suppressed.
    logic opcode_illegal;
    assign opcode_illegal = (instr_q[15:12] > 4'h6);

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        instr_d   = instr_q;
        retire_d  = retire_q;
        illegal_d = illegal_q;
        case (state_q)
            IDLE: begin
                if (run) state_d = FETCH;
            end
            FETCH: begin
                if (imem.imem_ack) begin
                    instr_d = imem.imem_rdata;
                    state_d = DECODE;
                end
            end
            DECODE: begin
                state_d = EXECUTE;
            end
            EXECUTE: begin
                pc_d     = (cu_load_pc && !opcode_illegal) ? cu_load_pc_val : pc_q + 1'b1;
                retire_d = retire_q + 16'd1;
                if (opcode_illegal) illegal_d = 1'b1;
                state_d  = run ? FETCH : IDLE;
            end
            default: state_d = IDLE;
        endcase
        // Request is registered so it rises exactly with the FETCH state.
        req_d = (state_d == FETCH);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            pc_q      <= RESET_PC;
            instr_q   <= 16'h0000;
            retire_q  <= 16'h0000;
            illegal_q <= 1'b0;
            req_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            instr_q   <= instr_d;
            retire_q  <= retire_d;
            illegal_q <= illegal_d;
            req_q     <= req_d;
        end
    end

    assign imem.imem_req   = req_q;
    assign imem.imem_addr  = pc_q;
    assign instr           = instr_q;
    assign pc              = pc_q;
    assign state           = state_q;
    assign retire_count    = retire_q;
    assign illegal_op      = illegal_q;
    assign rf_write_strobe = (state_q == EXECUTE) && cu_reg_write_enable && !opcode_illegal;

endmodule

// File: tb/tb_microcpu_sequencer.sv
// tb/tb_microcpu_sequencer.sv - directed bench with an instruction-level reference model
module tb_microcpu_sequencer;
    localparam int PW = 12;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          run = 1'b0;
    logic [15:0]   instr;
    logic          cu_we, cu_ld;
    logic [PW-1:0] cu_val;
    logic          strobe;
    logic [PW-1:0] pc;
    logic [1:0]    state;
    logic [15:0]   rc;
    logic          ill;

    microcpu_sequencer_if #(.PC_WIDTH(PW)) bus ();

    microcpu_sequencer #(.PC_WIDTH(PW), .RESET_PC(12'h000)) dut (
        .clk                 (clk),
        .rst                 (rst),
        .run                 (run),
        .imem                (bus),
        .instr               (instr),
        .cu_reg_write_enable (cu_we),
        .cu_load_pc          (cu_ld),
        .cu_load_pc_val      (cu_val),
        .rf_write_strobe     (strobe),
        .pc                  (pc),
        .state               (state),
        .retire_count        (rc),
        .illegal_op          (ill)
    );

    always #5 clk = ~clk;

    logic [15:0] imem [0:4095];
    bit          auto_mem  = 1'b1;
    int          ack_delay = 0;
    int          wait_cnt  = 0;
    logic        man_ack   = 1'b0;
    bit          force_we  = 1'b0;
    bit          force_ld  = 1'b0;
    int          checks    = 0;
    int          errors    = 0;
    bit          check_en  = 1'b0;

    assign bus.imem_ack   = auto_mem ? (bus.imem_req && wait_cnt == ack_delay) : man_ack;
    assign bus.imem_rdata = imem[bus.imem_addr];

    always @(posedge clk) begin
        if (!bus.imem_req || bus.imem_ack) wait_cnt <= 0;
        else                               wait_cnt <= wait_cnt + 1;
    end

    // Simple control unit: ALU ops 1..5 write, opcode 6 jumps to its immediate.
    assign cu_we  = force_we || (instr[15:12] >= 4'h1 && instr[15:12] <= 4'h5);
    assign cu_ld  = force_ld || (instr[15:12] == 4'h6);
    assign cu_val = instr[11:0];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: walks one instruction at a time, sampling inputs at each edge.
    logic [1:0]    m_state = 2'd0;
    logic [PW-1:0] m_pc    = 12'h000;
    logic [15:0]   m_instr = 16'h0000;
    logic [15:0]   m_rc    = 16'h0000;
    logic          m_ill   = 1'b0;

    task automatic step(output bit r);
        @(posedge clk);
        r = rst;
        if (rst) begin
            m_state = 2'd0;
            m_pc    = 12'h000;
            m_instr = 16'h0000;
            m_rc    = 16'h0000;
            m_ill   = 1'b0;
        end
    endtask

    initial begin : model_proc
        bit r;
        forever begin
            step(r);
            if (!r && run) begin
                m_state = 2'd1;
                forever begin
                    forever begin
                        step(r);
                        if (r || bus.imem_ack) break;
                    end
                    if (r) break;
                    m_instr = bus.imem_rdata;
                    m_state = 2'd2;
                    step(r);
                    if (r) break;
                    m_state = 2'd3;
                    step(r);
                    if (r) break;
                    if (m_instr[15:12] >= 4'h7) begin
                        m_ill = 1'b1;
                        m_pc  = m_pc + 12'd1;
                    end else begin
                        m_pc = cu_ld ? cu_val : m_pc + 12'd1;
                    end
                    m_rc = m_rc + 16'd1;
                    if (!run) begin
                        m_state = 2'd0;
                        break;
                    end
                    m_state = 2'd1;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (check_en) begin
            chk("cmp_state", 32'(state), 32'(m_state));
            chk("cmp_imem_req", 32'(bus.imem_req), 32'(m_state == 2'd1));
            chk("cmp_imem_addr", 32'(bus.imem_addr), 32'(m_pc));
            chk("cmp_pc", 32'(pc), 32'(m_pc));
            chk("cmp_instr", 32'(instr), 32'(m_instr));
            chk("cmp_retire", 32'(rc), 32'(m_rc));
            chk("cmp_illegal", 32'(ill), 32'(m_ill));
            chk("cmp_strobe", 32'(strobe),
                32'(m_state == 2'd3 && m_instr[15:12] < 4'h7 && cu_we));
        end
    end

    task automatic next();
        @(posedge clk);
        #1;
    endtask

    initial begin
        for (int i = 0; i < 4096; i++) imem[i] = 16'h0000;
        imem[0]      = 16'h1123;
        imem[1]      = 16'h2345;
        imem[5]      = 16'h6ABC;
        imem[12'hABC] = 16'h6FFF;

        next();
        check_en = 1'b1;
        next();
        chk("lit_reset_state", 32'(state), 32'd0);
        chk("lit_reset_pc", 32'(pc), 32'h000);
        chk("lit_reset_instr", 32'(instr), 32'h0000);
        chk("lit_reset_req", 32'(bus.imem_req), 32'd0);
        chk("lit_reset_rc", 32'(rc), 32'd0);

        // ADD at 0 with immediate ack
        rst = 1'b0;
        run = 1'b1;
        next();
        chk("lit_t1_req_c1", 32'(bus.imem_req), 32'd1);
        chk("lit_t1_addr_c1", 32'(bus.imem_addr), 32'h000);
        next();
        chk("lit_t1_instr_c2", 32'(instr), 32'h1123);
        chk("lit_t1_strobe_c2", 32'(strobe), 32'd0);
        next();
        chk("lit_t1_strobe_c3", 32'(strobe), 32'd1);
        run = 1'b0;
        next();
        chk("lit_t1_pc", 32'(pc), 32'h001);
        chk("lit_t1_rc", 32'(rc), 32'd1);
        chk("lit_t1_idle", 32'(state), 32'd0);
        chk("lit_t1_model_pc", 32'(m_pc), 32'h001);
        next();
        next();
        chk("lit_t1_no_req", 32'(bus.imem_req), 32'd0);

        // four wait cycles on the fetch of 2345 at pc=1
        ack_delay = 4;
        run = 1'b1;
        for (int c = 1; c <= 5; c++) begin
            next();
            chk("lit_t2_req", 32'(bus.imem_req), 32'd1);
            chk("lit_t2_addr", 32'(bus.imem_addr), 32'h001);
            if (c < 5) chk("lit_t2_instr_hold", 32'(instr), 32'h1123);
        end
        next();
        chk("lit_t2_instr", 32'(instr), 32'h2345);
        next();
        chk("lit_t2_exec_c7", 32'(state), 32'd3);
        chk("lit_t2_strobe_c7", 32'(strobe), 32'd1);
        run = 1'b0;
        next();
        chk("lit_t2_pc", 32'(pc), 32'h002);
        chk("lit_t2_rc", 32'(rc), 32'd2);
        ack_delay = 0;

        // NOPs 2..4, JMP ABC at 5, JMP FFF at ABC, NOP at FFF wraps to 0
        run = 1'b1;
        for (int c = 1; c <= 9; c++) next();
        next();
        chk("lit_t3_addr5", 32'(bus.imem_addr), 32'h005);
        next();
        next();
        chk("lit_t3_jmp_instr", 32'(instr), 32'h6ABC);
        chk("lit_t3_jmp_strobe", 32'(strobe), 32'd0);
        next();
        chk("lit_t3_addr_abc", 32'(bus.imem_addr), 32'hABC);
        chk("lit_t3_req_abc", 32'(bus.imem_req), 32'd1);
        chk("lit_t3_rc6", 32'(rc), 32'd6);
        chk("lit_t3_model_pc", 32'(m_pc), 32'hABC);
        next();
        next();
        next();
        chk("lit_t3_addr_fff", 32'(bus.imem_addr), 32'hFFF);
        next();
        next();
        chk("lit_t3_nop_strobe", 32'(strobe), 32'd0);
        chk("lit_t3_nop_exec", 32'(state), 32'd3);
        run = 1'b0;
        next();
        chk("lit_t3_wrap_pc", 32'(pc), 32'h000);
        chk("lit_t3_rc8", 32'(rc), 32'd8);

        // illegal opcode F with forced write-enable and jump request
        imem[0]  = 16'hF123;
        force_we = 1'b1;
        force_ld = 1'b1;
        run = 1'b1;
        next();
        next();
        chk("lit_t5_instr", 32'(instr), 32'hF123);
        next();
        chk("lit_t5_strobe", 32'(strobe), 32'd0);
        next();
        chk("lit_t5_ill", 32'(ill), 32'd1);
        chk("lit_t5_pc", 32'(pc), 32'h001);
        chk("lit_t5_rc", 32'(rc), 32'd9);
        force_we = 1'b0;
        force_ld = 1'b0;
        next();
        next();
        chk("lit_t5_next_strobe", 32'(strobe), 32'd1);
        run = 1'b0;
        next();
        chk("lit_t5_ill_sticky", 32'(ill), 32'd1);
        chk("lit_t5_pc2", 32'(pc), 32'h002);
        chk("lit_t5_rc10", 32'(rc), 32'd10);

        // reset mid-FETCH, ack arrives the cycle after
        auto_mem = 1'b0;
        man_ack  = 1'b0;
        run = 1'b1;
        next();
        chk("lit_t6_req", 32'(bus.imem_req), 32'd1);
        run = 1'b0;
        rst = 1'b1;
        next();
        chk("lit_t6_state", 32'(state), 32'd0);
        chk("lit_t6_pc", 32'(pc), 32'h000);
        chk("lit_t6_req_drop", 32'(bus.imem_req), 32'd0);
        chk("lit_t6_ill_clr", 32'(ill), 32'd0);
        rst     = 1'b0;
        man_ack = 1'b1;
        next();
        chk("lit_t6_ack_ignored", 32'(instr), 32'h0000);
        chk("lit_t6_still_idle", 32'(state), 32'd0);
        man_ack  = 1'b0;
        auto_mem = 1'b1;

        // opcode 7 is the first illegal value
        imem[0]  = 16'h7001;
        force_we = 1'b1;
        run = 1'b1;
        next();
        next();
        next();
        chk("lit_t7_strobe", 32'(strobe), 32'd0);
        run = 1'b0;
        next();
        chk("lit_t7_ill", 32'(ill), 32'd1);
        chk("lit_t7_pc", 32'(pc), 32'h001);
        chk("lit_t7_rc", 32'(rc), 32'd1);
        force_we = 1'b0;
        next();
        next();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/microcpu_sequencer.md
# microcpu_sequencer

Multi-cycle fetch/decode/execute sequencer for the 16-bit microcpu. It fetches instructions from instruction memory over a req/ack handshake and holds the instruction word stable for the control unit. It commits register-file writes as a single-cycle strobe and owns the 12-bit program counter, including JMP redirection. It sits between instruction memory, the control unit and the register file/ALU datapath.

## Interface
- PC_WIDTH, 12, program-counter width; must equal the JMP immediate width.
- RESET_PC, 12'h000, PC value loaded on reset.
- clk  in  1  system clock; all state changes on its rising edge.
- rst  in  1  synchronous, active-high reset.
- run  in  1  level enable; high starts/continues execution, low parks in IDLE at the next instruction boundary.
- imem_req  out  1  instruction fetch request.
- imem_addr  out  PC_WIDTH  fetch address (equals pc).
- imem_rdata  in  16  instruction word; valid when imem_ack=1.
- imem_ack  in  1  fetch complete.
- instr  out  16  latched instruction register; drives control-unit instruction input.
- cu_reg_write_enable  in  1  control-unit write-enable for the current instr.
- cu_load_pc  in  1  control-unit jump request.
- cu_load_pc_val  in  12  control-unit jump target.
- rf_write_strobe  out  1  one-cycle register-file write commit.
- pc  out  PC_WIDTH  program counter.
- state  out  2  FSM state: IDLE=0, FETCH=1, DECODE=2, EXECUTE=3.
- retire_count  out  16  instructions retired; wraps 16'hFFFF→0.
- illegal_op  out  1  sticky; set when an opcode > 4'h6 is executed.

## Operation
- FSM states:
  - **IDLE:** outputs quiescent. Moves to FETCH when run=1.
  - **FETCH:** imem_req=1 and imem_addr=pc, held stable until imem_ack. When imem_ack=1, instr<=imem_rdata and the FSM moves to DECODE. An ack in the first FETCH cycle is legal.
  - **DECODE:** one cycle; the control unit settles on the new instr. The FSM always moves to EXECUTE.
  - **EXECUTE:** one cycle.
    - rf_write_strobe = cu_reg_write_enable, asserted combinationally and only in this state.
    - At the clock edge, pc <= cu_load_pc ? cu_load_pc_val : pc+1. Increment wraps 12'hFFF→12'h000.
    - retire_count increments.
    - Next state is FETCH if run=1, else IDLE.
- Illegal opcode (instr[15:12] ≥ 4'h7), decoded from instr directly:
  - rf_write_strobe and cu_load_pc are forced inactive.
  - pc advances by 1 and the instruction still retires.
  - illegal_op is set; only rst clears it.
- NOP (opcode 0): no strobe, pc+1, retires.
- Inputs are ignored where they do not apply:
  - imem_ack outside FETCH.
  - run outside IDLE/EXECUTE; an in-flight instruction always completes.
  - cu_* inputs outside EXECUTE.

## Timing
- Reset values: state=IDLE, pc=RESET_PC, instr=16'h0000, imem_req=0, rf_write_strobe=0, retire_count=0, illegal_op=0; imem_addr follows pc.
- Reset has priority over every transition. Reset during FETCH drops imem_req on the following cycle, and a late ack is ignored.
- Zero-wait memory gives 3 cycles per instruction, FETCH→DECODE→EXECUTE. Each wait cycle (ack low in FETCH) adds 1.
- IDLE→first imem_req: 1 cycle after run rises.
- pc and retire_count update at the end of EXECUTE and are visible in the following FETCH. imem_addr in that FETCH is the new pc.
- rf_write_strobe is high for exactly one cycle per writing instruction and never for two consecutive cycles.
- run low in EXECUTE: the instruction retires and the FSM enters IDLE next. With run high the FSM goes straight to FETCH with no IDLE bubble.

## Test plan
- Reset then run=1, memory acks immediately with 16'h1123 (ADD) at addr 0 → imem_req in cycle 1; rf_write_strobe for 1 cycle in cycle 3; pc=1 and retire_count=1 after cycle 3.
- Ack delayed 4 cycles → imem_req and imem_addr stable throughout; instr captured only on the ack cycle; instruction takes 7 cycles.
- 16'h6ABC at pc=5 with cu_load_pc=1, cu_load_pc_val=12'hABC → no strobe; next imem_addr=12'hABC; retire_count+1.
- pc=12'hFFF executing NOP → pc wraps to 12'h000; no strobe.
- Opcode 4'hF with cu_reg_write_enable forced 1 → no strobe; illegal_op=1 and stays set through later instructions; pc+1.
- rst asserted mid-FETCH, ack arrives the next cycle → state=IDLE, pc=RESET_PC, instr=0, ack ignored; run low during EXECUTE → instruction retires, state=IDLE, no further imem_req.
